// File: rtl/fft_pkg.sv
// Shared constants and bundles for the MDC FFT twiddle datapath.
// Q7 twiddles, 16-bit samples, 16-sample frames.
package fft_pkg;

  localparam int DATA_W    = 16;
  localparam int TW_W      = 9;
  localparam int TW_FRAC   = 7;
  localparam int FRAME_LEN = 16;

  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int PROD_W = DATA_W + TW_W + 1;
  localparam int OUT_W  = DATA_W + 1;

  localparam logic signed [PROD_W-1:0] ROUND_CONST =
    PROD_W'(1) <<< (TW_FRAC - 1);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cmul_q7.sv
// Two-stage complex multiply by a Q7 twiddle with round-half-up,
// carrying valid and a bypass flag alongside the data.
module cmul_q7
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_bypass,
  input  cplx_t                   in_x,
  input  logic signed [TW_W-1:0]  w_r,
  input  logic signed [TW_W-1:0]  w_i,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im
);

  logic                     v2;
  logic                     byp2;
  cplx_t                    x2;
  logic signed [PROD_W-1:0] pr2;
  logic signed [PROD_W-1:0] pi2;

  logic signed [PROD_W-1:0] a;
  logic signed [PROD_W-1:0] b;
  logic signed [PROD_W-1:0] c;
  logic signed [PROD_W-1:0] d;

  assign a = PROD_W'(in_x.re);
  assign b = PROD_W'(in_x.im);
  assign c = PROD_W'(w_r);
  assign d = PROD_W'(w_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      byp2 <= 1'b0;
      x2   <= '0;
      pr2  <= '0;
      pi2  <= '0;
    end else begin
      v2   <= in_valid;
      byp2 <= in_bypass;
      x2   <= in_x;
      pr2  <= a * c - b * d;
      pi2  <= a * d + b * c;
    end
  end

  // Bound on |x|*sqrt(2) keeps the shifted result inside OUT_W bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        if (byp2) begin
          out_re <= OUT_W'(x2.re);
          out_im <= OUT_W'(x2.im);
        end else begin
          out_re <= OUT_W'((pr2 + ROUND_CONST) >>> TW_FRAC);
          out_im <= OUT_W'((pi2 + ROUND_CONST) >>> TW_FRAC);
        end
      end
    end
  end

endmodule

// File: rtl/mdc_twiddle_mult8.sv
// Twiddle lane of a 32-point MDC stage: frame counter, ROM address,
// and 3-cycle rotate/bypass pipeline.
module mdc_twiddle_mult8
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sync,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic [2:0]               rom_8_counter,
  input  logic signed [TW_W-1:0]   w_r,
  input  logic signed [TW_W-1:0]   w_i,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx1;
  logic [CNT_W-1:0] idx_now;
  logic             v1;
  cplx_t            x1;

  assign idx_now = in_sync ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx1 <= '0;
      v1   <= 1'b0;
      x1   <= '0;
    end else if (in_valid) begin
      cnt  <= idx_now + 1'b1;
      idx1 <= idx_now;
      v1   <= 1'b1;
      x1   <= '{re: in_re, im: in_im};
    end else begin
      v1 <= 1'b0;
    end
  end

  // Address tracks the held index even in the bypass half.
  assign rom_8_counter = idx1[2:0];

  cmul_q7 u_cmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_bypass (~idx1[CNT_W-1]),
    .in_x      (x1),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im)
  );

endmodule

// File: tb/tb_mdc_twiddle_mult8.sv
// Scoreboard bench: frame-index model feeds an expected-result queue,
// monitor pops and compares value and arrival cycle.
module tb_mdc_twiddle_mult8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_sync = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic [2:0]         rom_8_counter;
  logic signed [8:0]  w_r;
  logic signed [8:0]  w_i;
  logic               out_valid;
  logic signed [16:0] out_re;
  logic signed [16:0] out_im;

  localparam logic signed [8:0] ROM_R [8] = '{
    9'sd128, 9'sd118, 9'sd90, 9'sd48,
    9'sd0, -9'sd48, -9'sd90, -9'sd118};
  localparam logic signed [8:0] ROM_I [8] = '{
    9'sd0, -9'sd48, -9'sd90, -9'sd118,
    -9'sd128, -9'sd118, -9'sd90, -9'sd48};

  assign w_r = ROM_R[rom_8_counter];
  assign w_i = ROM_I[rom_8_counter];

  mdc_twiddle_mult8 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_sync       (in_sync),
    .in_re         (in_re),
    .in_im         (in_im),
    .rom_8_counter (rom_8_counter),
    .w_r           (w_r),
    .w_i           (w_i),
    .out_valid     (out_valid),
    .out_re        (out_re),
    .out_im        (out_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int re;
    int im;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   mcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic int floor128(longint v);
    if (v >= 0) return int'(v / 128);
    return int'(-((-v + 127) / 128));
  endfunction

  function automatic int wrap17(int v);
    int m;
    m = v & 32'h1ffff;
    if (m >= 65536) m = m - 131072;
    return m;
  endfunction

  function automatic exp_t model(int idx, int a, int b, int t);
    exp_t e;
    longint c, d;
    e.t = t;
    if (idx < 8) begin
      e.re = a;
      e.im = b;
    end else begin
      c = ROM_R[idx - 8];
      d = ROM_I[idx - 8];
      e.re = wrap17(floor128(a * c - b * d + 64));
      e.im = wrap17(floor128(a * d + b * c + 64));
    end
    return e;
  endfunction

  task automatic drive(bit v, bit s, int re, int im);
    int idx;
    in_valid = v;
    in_sync  = s;
    in_re    = 16'(re);
    in_im    = 16'(im);
    @(posedge clk);
    #1;
    if (v) begin
      idx  = s ? 0 : mcnt;
      mcnt = (idx + 1) % 16;
      q.push_back(model(idx, re, im, cyc + 2));
      chk("rom_addr", int'(rom_8_counter), idx % 8);
    end
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic bubbles(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic rst_checks(string tag);
    chk({tag, "_ovalid"}, int'(out_valid), 0);
    chk({tag, "_ore"}, int'(out_re), 0);
    chk({tag, "_oim"}, int'(out_im), 0);
    chk({tag, "_rom"}, int'(rom_8_counter), 0);
  endtask

  task automatic do_reset(int n);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      @(posedge clk);
      #1;
      q.delete();
      rst_checks("in_rst");
    end
    mcnt     = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rst_checks("post_rst");
    end
  endtask

  function automatic int rdata();
    case ($urandom_range(0, 5))
      0: return 32767;
      1: return -32768;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.t);
        chk("out_re", int'(out_re), e.re);
        chk("out_im", int'(out_im), e.im);
      end
    end else if (q.size() != 0 && q[0].t <= cyc) begin
      e = q.pop_front();
      chk("missing_out", 0, 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit v, s;
    @(posedge clk);
    #1;
    do_reset(3);

    drive(1, 1, 11, -22);
    for (int i = 1; i < 5; i++) drive(1, 0, rdata(), rdata());
    drive(1, 0, -1234, 567);
    drive(1, 0, 7, 8);
    drive(1, 0, 9, 10);
    drive(1, 0, -3, 4);
    drive(1, 0, 1000, 0);
    drive(1, 0, 100, 0);
    drive(1, 0, rdata(), rdata());
    drive(1, 0, 100, 50);
    for (int i = 13; i < 16; i++) drive(1, 0, rdata(), rdata());

    drive(1, 1, rdata(), rdata());
    for (int i = 1; i < 7; i++) drive(1, 0, rdata(), rdata());
    bubbles(3);
    drive(1, 0, 555, -555);
    drive(1, 0, rdata(), rdata());
    drive(1, 0, rdata(), rdata());
    drive(1, 0, 32767, 32767);
    drive(1, 1, 4321, -4321);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 12; i++) drive(1, 0, rdata(), rdata());

    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 24) == 0);
      drive(v, s, rdata(), rdata());
    end

    for (int i = 0; i < 5; i++) drive(1, 0, rdata(), rdata());
    do_reset(1);

    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 4) != 0);
      s = ($urandom_range(0, 30) == 0);
      drive(v, s, rdata(), rdata());
    end

    bubbles(6);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
